// File: rtl/pr_pkg.sv
// Shared definitions for the priority-encoder request path (pr_en / pr_dec_dispatch).
//   pr_state_e      dispatcher FSM encoding
//   PR_DATA_WIDTH   default number of request lines
//   PR_TIMEOUT      default grant timeout in cycles (0 disables)
//   pr_width()      $clog2 clamped to at least 1 bit
package pr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } pr_state_e;

  localparam int unsigned PR_DATA_WIDTH = 4;
  localparam int unsigned PR_TIMEOUT    = 8;

  // Keeps degenerate widths (1 line, timeout 0) from producing zero-width vectors.
  function automatic int unsigned pr_width(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/bin2onehot.sv
// Combinational binary-to-one-hot decoder.
//   code_i      encoded index
//   onehot_o    one-hot decode, all-zero when code_i >= DATA_WIDTH
//   in_range_o  code_i addresses an existing line
module bin2onehot
  import pr_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = PR_DATA_WIDTH,
  localparam int unsigned SEL_WIDTH  = pr_width(DATA_WIDTH)
) (
  input  logic [SEL_WIDTH-1:0]  code_i,
  output logic [DATA_WIDTH-1:0] onehot_o,
  output logic                  in_range_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      onehot_o[i] = (code_i == SEL_WIDTH'(i));
    end
  end

  // Out-of-range codes match no line, so an empty decode is exactly the range error.
  assign in_range_o = |onehot_o;

endmodule

// File: rtl/pr_dec_dispatch.sv
// Receive side of the priority-encoder request path: turns an encoded index into a
// registered one-hot grant and holds it until the serviced unit acks or a timeout fires.
//   clk, rst       clock; synchronous active-high reset
//   code_in        encoded index from pr_en
//   valid_in       code_in valid
//   ready_out      a code can be accepted this cycle (FSM idle)
//   grant_out      registered one-hot grant, all-zero when idle
//   ack_in         serviced unit done, releases the grant
//   done_out       1-cycle pulse: grant released by ack_in
//   timeout_err    1-cycle pulse: grant released by timeout
//   range_err      1-cycle pulse: out-of-range code rejected
module pr_dec_dispatch
  import pr_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH = PR_DATA_WIDTH,
  parameter int unsigned  TIMEOUT    = PR_TIMEOUT,
  localparam int unsigned SEL_WIDTH  = pr_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_WIDTH-1:0]  code_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] grant_out,
  input  logic                  ack_in,
  output logic                  done_out,
  output logic                  timeout_err,
  output logic                  range_err
);

  localparam int unsigned CntWidth = pr_width(TIMEOUT + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);

  pr_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] grant_q, grant_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  tout_q, tout_d;
  logic                  range_q, range_d;

  logic [DATA_WIDTH-1:0] dec_onehot;
  logic                  dec_in_range;

  bin2onehot #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bin2onehot (
    .code_i     (code_in),
    .onehot_o   (dec_onehot),
    .in_range_o (dec_in_range)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    tout_d  = 1'b0;
    range_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          if (dec_in_range) begin
            grant_d = dec_onehot;
            cnt_d   = '0;
            state_d = ST_GRANT;
          end else begin
            range_d = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        // ack beats a timeout landing in the same cycle.
        if (ack_in) begin
          grant_d = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
          grant_d = '0;
          tout_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      range_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      range_q <= range_d;
    end
  end

  assign ready_out   = (state_q == ST_IDLE);
  assign grant_out   = grant_q;
  assign done_out    = done_q;
  assign timeout_err = tout_q;
  assign range_err   = range_q;

endmodule
